kbd_mmio_responder: RTL and testbench
=====================================

Name: kbd_mmio_responder

Overview:
- PS/2 keyboard responder for the 0xe0000000 MMIO window decoded by the CPU interface.
- Receives PS/2 frames from the keyboard and buffers scancodes in a FIFO.
- Answers CPU data-memory reads and writes on the same dmem signals used by the data cache: dmem_read_in, dmem_write_in, dmem_addr, data_from_reg, dmem_byte_w_en.
- Runs in the ui_clk domain; keyboard pins are asynchronous inputs.

Parameters:
- FIFO_DEPTH, 16, scancode FIFO entries; must be a power of 2, minimum 2.
- TIMEOUT_CYCLES, 20000, clk cycles without a PS/2 falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock (ui_clk)
- rst  in  1  asynchronous, active-low reset
- ps2_clk  in  1  keyboard clock, asynchronous
- ps2_data  in  1  keyboard data, asynchronous
- kbd_sel  in  1  dmem_addr[31:28]==4'he, decoded upstream
- dmem_read_in  in  1  CPU load strobe, one cycle per access
- dmem_write_in  in  1  CPU store strobe
- dmem_addr  in  4  word offset; bits [3:2] are used
- data_from_reg  in  32  store data
- kbd_data_out  out  32  read data, combinational
- kbd_irq  out  1  level high while the FIFO is non-empty

Behaviour:
- Synchronisation: ps2_clk and ps2_data each pass through 2 flops. A falling edge is detected from the synced ps2_clk plus one extra history flop.
- Receive FSM (ps2_rx) states: IDLE, DATA, PARITY, STOP.
  - IDLE→DATA on a falling edge with data=0 (start bit). A start bit of 1 stays in IDLE.
  - DATA shifts 8 bits LSB-first with a 3-bit counter; after the 8th bit → PARITY.
  - PARITY captures the bit → STOP.
  - STOP: data=1 emits a one-cycle byte_valid and returns to IDLE. Data=0 sets frame_err and returns to IDLE with no push.
  - Watchdog counter clears on every falling edge. Reaching TIMEOUT_CYCLES in any non-IDLE state → IDLE, partial byte discarded, no error flag.
- FIFO:
  - Write pointer, read pointer and count are each log2(FIFO_DEPTH)+1 bits.
  - Push on byte_valid.
  - Pop on the rising edge of a cycle with kbd_sel & dmem_read_in & offset 0 & count!=0.
  - Push when full with no simultaneous pop: byte dropped, overflow sticky bit set.
  - Push and pop in the same cycle: both happen and count is unchanged, including when full.
- Register map (offset = dmem_addr[3:2]):
  - 0 DATA: {24'd0, head byte}; reads 0 when empty; a read pops.
  - 1 STATUS: bit0 = non-empty, bit1 = overflow, bit2 = frame_err, bit3 = parity_err, bits[12:8] = count (zero-extended), other bits 0. Reads have no side effect.
  - 2 CTRL: a write with data_from_reg[0]=1 flushes the FIFO (pointers to 0). Bits [3:1] = 1 clear overflow, frame_err and parity_err respectively. Reads return 0.
  - 3: reads 0, writes ignored.
- Read data is combinational from the current state in the same cycle as the strobe; there is no stall.
- Writes to DATA or STATUS are ignored. dmem_byte_w_en is ignored; whole-word semantics.
- A flush and a push in the same cycle: flush wins and the byte is lost.
- A flush and a sticky-set in the same cycle: the set wins.
- Reset (async assert, sync release):
  - FSM → IDLE; pointers, count and all sticky bits → 0.
  - kbd_irq=0; kbd_data_out=0 when not selected.
  - Reset mid-frame discards the partial byte.
- kbd_data_out is 0 whenever kbd_sel=0 or dmem_read_in=0.

Optional Feature:
- Macro: KBD_PARITY_CHECK_EN.
- Defined: in PARITY, if data bits XOR parity bit != 1 (odd-parity failure), set parity_err, suppress byte_valid at STOP and push nothing.
- Undefined: the parity bit is sampled and ignored; STATUS bit3 reads 0 and its CTRL clear is a no-op.

Decomposition:
- Package kbd_pkg holds:
  - register offsets KBD_REG_DATA/STATUS/CTRL;
  - STATUS bit indices;
  - CTRL bit indices;
  - the FSM state encoding;
  - KBD_REGION nibble 4'he.
- One sub-module, ps2_rx: synchronisers, edge detect, FSM, watchdog. Outputs byte, byte_valid, frame_err_pulse, parity_err_pulse.
- The FIFO and register decode live in the top module.

Test Plan:
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) at a 10 kHz PS/2 clock, then STATUS read → 0x00000101. DATA read → 0x0000001C. Next STATUS read → 0.
- Send 17 frames 0x01..0x11 with FIFO_DEPTH=16 → STATUS = 0x00001003. Draining returns 0x01..0x10 in order. Write CTRL=0x2 → overflow cleared.
- Push at the same cycle as a DATA read while full → count stays 16 and the new byte is appended after 0x10.
- Frame with stop bit 0 → no push, STATUS bit2=1. Bad parity with KBD_PARITY_CHECK_EN → bit3=1, count 0. Bad parity without the macro → byte pushed.
- 5 bits then silence for TIMEOUT_CYCLES+1, then a full frame 0x29 → only 0x29 in the FIFO, no error bits.
- Assert rst low mid-frame with 3 bytes queued → count 0, kbd_irq 0. A frame after release is received correctly.

Source files
------------

// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kbd_pkg
// Description : Shared definitions for the PS/2 keyboard MMIO responder.
//               Holds the register offsets, STATUS/CTRL bit positions, the
//               MMIO region nibble and the PS/2 receive FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    // Upper address nibble of the keyboard window (decoded upstream).
    localparam logic [3:0] KBD_REGION = 4'he;

    // Register offsets (dmem_addr[3:2]).
    localparam logic [1:0] KBD_REG_DATA   = 2'd0;
    localparam logic [1:0] KBD_REG_STATUS = 2'd1;
    localparam logic [1:0] KBD_REG_CTRL   = 2'd2;

    // STATUS bit positions.
    localparam int KBD_ST_NONEMPTY   = 0;
    localparam int KBD_ST_OVERFLOW   = 1;
    localparam int KBD_ST_FRAME_ERR  = 2;
    localparam int KBD_ST_PARITY_ERR = 3;
    localparam int KBD_ST_COUNT_LSB  = 8;
    localparam int KBD_ST_COUNT_W    = 5;

    // CTRL bit positions.
    localparam int KBD_CTRL_FLUSH   = 0;
    localparam int KBD_CTRL_CLR_OVF = 1;
    localparam int KBD_CTRL_CLR_FRM = 2;
    localparam int KBD_CTRL_CLR_PAR = 3;

    // PS/2 receive FSM encoding.
    typedef enum logic [1:0] {
        PS2_IDLE   = 2'd0,
        PS2_DATA   = 2'd1,
        PS2_PARITY = 2'd2,
        PS2_STOP   = 2'd3
    } ps2_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 device-to-host frame receiver. Synchronises the keyboard
//               pins, detects ps2_clk falling edges, shifts in start/8 data/
//               parity/stop bits and abandons stalled frames via a watchdog.
//               Optional macro KBD_PARITY_CHECK_EN enables odd-parity
//               checking; otherwise the parity bit is sampled and ignored.
// Ports       : clk, rst (async active-low), ps2_clk/ps2_data (async pins),
//               rx_byte (received byte), byte_valid (1-cycle pulse),
//               frame_err_pulse (bad stop bit), parity_err_pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err_pulse,
    output logic       parity_err_pulse
);

    localparam int               c_wd_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_wd_w-1:0] c_timeout = c_wd_w'(TIMEOUT_CYCLES);

    logic [1:0]        r_clk_sync;
    logic [1:0]        r_dat_sync;
    logic              r_clk_prev;
    ps2_state_t        r_state;
    ps2_state_t        w_state_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_next;
    logic [c_wd_w-1:0] r_wdog;
    logic              w_fall;
    logic              w_bit;
    logic              w_timeout;
`ifdef KBD_PARITY_CHECK_EN
    logic              r_par_bad;
    logic              w_par_bad_next;
`endif

    // Pins idle high, so synchronisers reset to 1 to avoid a fake edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync[1];
    assign w_bit     = r_dat_sync[1];
    assign w_timeout = (r_state != PS2_IDLE) && (r_wdog == c_timeout);

    // Watchdog: counts idle clocks between falling edges inside a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if (w_fall || (r_state == PS2_IDLE)) begin
            r_wdog <= '0;
        end else if (!w_timeout) begin
            r_wdog <= r_wdog + c_wd_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= PS2_IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
`ifdef KBD_PARITY_CHECK_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_cnt     <= w_cnt_next;
`ifdef KBD_PARITY_CHECK_EN
            r_par_bad <= w_par_bad_next;
`endif
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_shift_next     = r_shift;
        w_cnt_next       = r_cnt;
        byte_valid       = 1'b0;
        frame_err_pulse  = 1'b0;
        parity_err_pulse = 1'b0;
`ifdef KBD_PARITY_CHECK_EN
        w_par_bad_next   = r_par_bad;
`endif
        if (w_fall) begin
            case (r_state)
                PS2_IDLE: begin
                    if (!w_bit) begin
                        w_state_next = PS2_DATA;
                        w_cnt_next   = '0;
                    end
                end
                PS2_DATA: begin
                    // LSB first: each new bit enters at the top.
                    w_shift_next = {w_bit, r_shift[7:1]};
                    w_cnt_next   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_state_next = PS2_PARITY;
                    end
                end
                PS2_PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
                    // Odd parity: data bits plus parity bit must XOR to 1.
                    w_par_bad_next   = ~(^{r_shift, w_bit});
                    parity_err_pulse = w_par_bad_next;
`endif
                    w_state_next = PS2_STOP;
                end
                default: begin
                    w_state_next = PS2_IDLE;
                    if (w_bit) begin
`ifdef KBD_PARITY_CHECK_EN
                        byte_valid = ~r_par_bad;
`else
                        byte_valid = 1'b1;
`endif
                    end else begin
                        frame_err_pulse = 1'b1;
                    end
                end
            endcase
        end else if (w_timeout) begin
            w_state_next = PS2_IDLE;
        end
    end

    assign rx_byte = r_shift;

endmodule
`default_nettype wire

// File: rtl/kbd_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : kbd_mmio_responder
// Description : PS/2 keyboard responder for the 0xe0000000 MMIO window.
//               Buffers received scancodes in a FIFO and serves CPU dmem
//               accesses: DATA (read pops), STATUS, CTRL (flush / clears).
//               Optional macro KBD_PARITY_CHECK_EN enables parity errors.
// Ports       : clk, rst (async active-low), ps2_clk/ps2_data (async pins),
//               kbd_sel, dmem_read_in, dmem_write_in, dmem_addr[3:0],
//               data_from_reg[31:0], kbd_data_out[31:0] (combinational),
//               kbd_irq (FIFO non-empty).
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_mmio_responder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        kbd_sel,
    input  logic        dmem_read_in,
    input  logic        dmem_write_in,
    input  logic [3:0]  dmem_addr,
    input  logic [31:0] data_from_reg,
    output logic [31:0] kbd_data_out,
    output logic        kbd_irq
);

    localparam int                 c_addr_w = $clog2(FIFO_DEPTH);
    localparam int                 c_ptr_w  = c_addr_w + 1;
    localparam logic [c_ptr_w-1:0] c_depth  = c_ptr_w'(FIFO_DEPTH);

    logic [7:0]         w_rx_byte;
    logic               w_byte_valid;
    logic               w_frame_err_pulse;
    logic               w_parity_err_pulse;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_count;
    logic               r_overflow;
    logic               r_frame_err;
    logic               r_parity_err;
    logic [1:0]         w_offset;
    logic               w_nonempty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_ctrl_wr;
    logic               w_flush;
    logic               w_ovf_set;
    logic [7:0]         w_head;
    logic [31:0]        w_status;
    logic               w_unused_bits;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ps2_rx (
        .clk              (clk),
        .rst              (rst),
        .ps2_clk          (ps2_clk),
        .ps2_data         (ps2_data),
        .rx_byte          (w_rx_byte),
        .byte_valid       (w_byte_valid),
        .frame_err_pulse  (w_frame_err_pulse),
        .parity_err_pulse (w_parity_err_pulse)
    );

    assign w_offset   = dmem_addr[3:2];
    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == c_depth);
    assign w_head     = r_mem[r_rd_ptr[c_addr_w-1:0]];

    assign w_pop     = kbd_sel & dmem_read_in & (w_offset == KBD_REG_DATA) & w_nonempty;
    // A full FIFO still accepts a byte when a pop frees the head this cycle.
    assign w_push    = w_byte_valid & (~w_full | w_pop);
    assign w_ovf_set = w_byte_valid & w_full & ~w_pop;
    assign w_ctrl_wr = kbd_sel & dmem_write_in & (w_offset == KBD_REG_CTRL);
    assign w_flush   = w_ctrl_wr & data_from_reg[KBD_CTRL_FLUSH];

    // Storage has no reset; only slots below count are ever observed.
    always_ff @(posedge clk) begin
        if (w_push && !w_flush) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= w_rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_ptr_w'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_ptr_w'(1);
            end
        end
    end

    // Sticky flags: a set in the same cycle as its clear takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_overflow   <= w_ovf_set |
                            (r_overflow & ~(w_ctrl_wr & data_from_reg[KBD_CTRL_CLR_OVF]));
            r_frame_err  <= w_frame_err_pulse |
                            (r_frame_err & ~(w_ctrl_wr & data_from_reg[KBD_CTRL_CLR_FRM]));
            r_parity_err <= w_parity_err_pulse |
                            (r_parity_err & ~(w_ctrl_wr & data_from_reg[KBD_CTRL_CLR_PAR]));
        end
    end

    always_comb begin
        w_status                                           = '0;
        w_status[KBD_ST_NONEMPTY]                          = w_nonempty;
        w_status[KBD_ST_OVERFLOW]                          = r_overflow;
        w_status[KBD_ST_FRAME_ERR]                         = r_frame_err;
        w_status[KBD_ST_PARITY_ERR]                        = r_parity_err;
        w_status[KBD_ST_COUNT_LSB +: KBD_ST_COUNT_W]       = KBD_ST_COUNT_W'(r_count);
    end

    always_comb begin
        kbd_data_out = '0;
        if (kbd_sel && dmem_read_in) begin
            case (w_offset)
                KBD_REG_DATA: begin
                    if (w_nonempty) begin
                        kbd_data_out = {24'd0, w_head};
                    end
                end
                KBD_REG_STATUS: kbd_data_out = w_status;
                default:        kbd_data_out = '0;
            endcase
        end
    end

    assign kbd_irq = w_nonempty;

    assign w_unused_bits = ^{dmem_addr[1:0], data_from_reg[31:4]};

endmodule
`default_nettype wire

// File: tb/tb_kbd_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_kbd_mmio_responder
// Description : Self-checking bench for kbd_mmio_responder. A queue-based
//               reference model tracks the FIFO and sticky flags; a compare
//               process checks kbd_irq and kbd_data_out every quiet cycle,
//               and directed reads pin literal expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_mmio_responder;

    localparam int DEPTH = 16;
    localparam int TMO   = 200;
    localparam int HALF  = 10;

    logic        clk           = 1'b0;
    logic        rst           = 1'b0;
    logic        ps2_clk       = 1'b1;
    logic        ps2_data      = 1'b1;
    logic        kbd_sel       = 1'b0;
    logic        dmem_read_in  = 1'b0;
    logic        dmem_write_in = 1'b0;
    logic [3:0]  dmem_addr     = 4'd0;
    logic [31:0] data_from_reg = 32'd0;
    logic [31:0] kbd_data_out;
    logic        kbd_irq;

    kbd_mmio_responder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .kbd_sel       (kbd_sel),
        .dmem_read_in  (dmem_read_in),
        .dmem_write_in (dmem_write_in),
        .dmem_addr     (dmem_addr),
        .data_from_reg (data_from_reg),
        .kbd_data_out  (kbd_data_out),
        .kbd_irq       (kbd_irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] mq [$];
    bit         m_ovf  = 1'b0;
    bit         m_frm  = 1'b0;
    bit         m_par  = 1'b0;
    bit         busy   = 1'b0;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic sel, input logic rd, input logic [3:0] addr);
        logic [31:0] v;
        int          n;
        v = 32'd0;
        n = mq.size();
        if (sel && rd) begin
            if (addr[3:2] == 2'd0 && n != 0) v = {24'd0, mq[0]};
            if (addr[3:2] == 2'd1) v = (n * 256) + (m_par ? 8 : 0) + (m_frm ? 4 : 0)
                                       + (m_ovf ? 2 : 0) + ((n != 0) ? 1 : 0);
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (!busy) begin
            chk("irq", {31'd0, kbd_irq}, {31'd0, (mq.size() != 0)});
            chk("rdata", kbd_data_out, model_rd(kbd_sel, dmem_read_in, dmem_addr));
        end
    end

    task automatic cpu_read(input logic sel, input logic [1:0] off,
                            input logic [31:0] exp, input string name);
        @(posedge clk);
        #1;
        kbd_sel      = sel;
        dmem_read_in = 1'b1;
        dmem_addr    = {off, 2'b00};
        @(negedge clk);
        chk(name, kbd_data_out, exp);
        @(posedge clk);
        if (sel && off == 2'd0 && mq.size() != 0) void'(mq.pop_front());
        #1;
        kbd_sel      = 1'b0;
        dmem_read_in = 1'b0;
        dmem_addr    = 4'd0;
    endtask

    task automatic cpu_write(input logic [1:0] off, input logic [31:0] d);
        @(posedge clk);
        #1;
        kbd_sel       = 1'b1;
        dmem_write_in = 1'b1;
        dmem_addr     = {off, 2'b00};
        data_from_reg = d;
        @(posedge clk);
        if (off == 2'd2) begin
            if (d[0]) mq.delete();
            if (d[1]) m_ovf = 1'b0;
            if (d[2]) m_frm = 1'b0;
            if (d[3]) m_par = 1'b0;
        end
        #1;
        kbd_sel       = 1'b0;
        dmem_write_in = 1'b0;
        dmem_addr     = 4'd0;
        data_from_reg = 32'd0;
    endtask

    // Sends the first nbits of a frame (11 = complete). With pop_at_stop a
    // DATA read is issued in the exact cycle the byte is pushed.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit bad_par,
                              input bit bad_stop, input bit pop_at_stop);
        logic [10:0] b;
        logic        p;
        logic        s;
        p    = (~(^d)) ^ bad_par;
        s    = ~bad_stop;
        b    = {s, p, d, 1'b0};
        busy = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = b[i];
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (i == 10 && pop_at_stop) begin
                @(posedge clk);
                @(posedge clk);
                #1;
                kbd_sel      = 1'b1;
                dmem_read_in = 1'b1;
                dmem_addr    = 4'd0;
                @(negedge clk);
                chk("pop_at_push_head", kbd_data_out, {24'd0, mq[0]});
                @(posedge clk);
                #1;
                kbd_sel      = 1'b0;
                dmem_read_in = 1'b0;
                repeat (HALF - 3) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            #1 ps2_clk = 1'b1;
        end
        if (nbits == 11) begin
            if (pop_at_stop) begin
                void'(mq.pop_front());
                mq.push_back(d);
            end else if (bad_stop) begin
                m_frm = 1'b1;
`ifdef KBD_PARITY_CHECK_EN
            end else if (bad_par) begin
                m_par = 1'b1;
`endif
            end else if (mq.size() == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                mq.push_back(d);
            end
        end
        busy = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        cpu_read(1'b1, 2'd1, 32'h0, "status_in_reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Single frame 0x1C
        send_frame(8'h1C, 11, 1'b0, 1'b0, 1'b0);
        cpu_read(1'b1, 2'd1, 32'h0000_0101, "status_1c");
        cpu_read(1'b1, 2'd0, 32'h0000_001C, "data_1c");
        cpu_read(1'b1, 2'd1, 32'h0, "status_empty");
        cpu_read(1'b1, 2'd0, 32'h0, "data_empty");

        // Overflow: 17 frames into a 16-deep FIFO
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 11, 1'b0, 1'b0, 1'b0);
        cpu_read(1'b1, 2'd1, 32'h0000_1003, "status_full_ovf");
        cpu_read(1'b0, 2'd1, 32'h0, "unselected_read");
        cpu_read(1'b1, 2'd2, 32'h0, "ctrl_read");
        cpu_read(1'b1, 2'd3, 32'h0, "reg3_read");
        cpu_write(2'd1, 32'hFFFF_FFFF);
        cpu_write(2'd0, 32'hFFFF_FFFF);
        cpu_read(1'b1, 2'd1, 32'h0000_1003, "status_after_ignored_writes");

        // Push coinciding with a pop while full
        send_frame(8'h22, 11, 1'b0, 1'b0, 1'b1);
        cpu_read(1'b1, 2'd1, 32'h0000_1003, "status_pushpop_full");
        for (int i = 2; i <= 16; i++) cpu_read(1'b1, 2'd0, 32'(i), "drain");
        cpu_read(1'b1, 2'd0, 32'h22, "drain_tail");
        cpu_read(1'b1, 2'd1, 32'h0000_0002, "status_drained_ovf");
        cpu_write(2'd2, 32'h2);
        cpu_read(1'b1, 2'd1, 32'h0, "ovf_cleared");

        // Flush
        send_frame(8'h33, 11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h44, 11, 1'b0, 1'b0, 1'b0);
        cpu_read(1'b1, 2'd1, 32'h0000_0201, "status_two");
        cpu_write(2'd2, 32'h1);
        cpu_read(1'b1, 2'd1, 32'h0, "flushed");

        // Bad stop bit
        send_frame(8'h55, 11, 1'b0, 1'b1, 1'b0);
        cpu_read(1'b1, 2'd1, 32'h0000_0004, "frame_err");
        cpu_write(2'd2, 32'h4);
        cpu_read(1'b1, 2'd1, 32'h0, "frame_err_cleared");

        // Bad parity
        send_frame(8'h66, 11, 1'b1, 1'b0, 1'b0);
`ifdef KBD_PARITY_CHECK_EN
        cpu_read(1'b1, 2'd1, 32'h0000_0008, "parity_err");
`else
        cpu_read(1'b1, 2'd1, 32'h0000_0101, "parity_ignored");
        cpu_read(1'b1, 2'd0, 32'h0000_0066, "parity_ignored_data");
`endif
        cpu_write(2'd2, 32'h8);
        cpu_read(1'b1, 2'd1, 32'h0, "parity_cleared");

        // Partial frame abandoned by the watchdog
        send_frame(8'hAA, 6, 1'b0, 1'b0, 1'b0);
        repeat (TMO + 10) @(posedge clk);
        send_frame(8'h29, 11, 1'b0, 1'b0, 1'b0);
        cpu_read(1'b1, 2'd1, 32'h0000_0101, "status_after_timeout");
        cpu_read(1'b1, 2'd0, 32'h0000_0029, "data_after_timeout");
        cpu_read(1'b1, 2'd1, 32'h0, "status_timeout_empty");

        // Reset mid-frame with three bytes queued
        send_frame(8'h11, 11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 11, 1'b0, 1'b0, 1'b0);
        cpu_read(1'b1, 2'd1, 32'h0000_0301, "status_three");
        send_frame(8'h77, 4, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_frm = 1'b0;
        m_par = 1'b0;
        @(negedge clk);
        chk("irq_in_reset", {31'd0, kbd_irq}, 32'd0);
        cpu_read(1'b1, 2'd1, 32'h0, "status_mid_reset");
        @(posedge clk);
        #1 rst = 1'b1;
        send_frame(8'h5A, 11, 1'b0, 1'b0, 1'b0);
        cpu_read(1'b1, 2'd1, 32'h0000_0101, "status_after_reset");
        cpu_read(1'b1, 2'd0, 32'h0000_005A, "data_after_reset");

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
